// File: rtl/aes_vector_sequencer.sv
// aes_vector_sequencer: buffers {key, pt, exp} vectors and runs them through an external AES core.
// Define AES_SEQ_MISMATCH_LOG_EN to build the first-mismatch log (first_fail_idx / first_fail_ct).
module aes_vector_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vec_valid,
    output logic               vec_ready,
    input  logic [127:0]       vec_key,
    input  logic [127:0]       vec_pt,
    input  logic [127:0]       vec_exp,
    input  logic               start,
    output logic               core_ld,
    output logic [127:0]       core_key,
    output logic [127:0]       core_text,
    input  logic               core_done,
    input  logic [127:0]       core_ct,
    output logic               busy,
    output logic               finished,
    output logic               timeout_err,
    output logic [CNT_W-1:0]   pass_cnt,
    output logic [CNT_W-1:0]   fail_cnt,
    output logic [CNT_W-1:0]   first_fail_idx,
    output logic [127:0]       first_fail_ct
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, CHECK, DONE} state_t;

    state_t              state_q;
    logic [383:0]        mem_q [DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [AW:0]         cnt_q, cnt_d;
    logic [TW-1:0]       wcnt_q;
    logic [CNT_W-1:0]    pass_q, fail_q, idx_q;
    logic [127:0]        ct_q, head_key, head_pt, head_exp;
    logic                busy_q, finished_q, core_ld_q, tmo_q, timed_out_q, done_prev_q;
    logic                push, pop, run_start, done_rise, fail_now;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

    assign {head_key, head_pt, head_exp} = mem_q[rd_q];
    assign vec_ready   = cnt_q != (AW+1)'(DEPTH);
    assign push        = vec_valid && vec_ready;
    assign pop         = state_q == CHECK;
    assign cnt_d       = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    assign run_start   = (state_q == IDLE || state_q == DONE) && start && cnt_q != '0;
    assign done_rise   = core_done && !done_prev_q;
    assign fail_now    = timed_out_q || ct_q != head_exp;
    assign core_ld     = core_ld_q;
    assign core_key    = busy_q ? head_key : '0;
    assign core_text   = busy_q ? head_pt : '0;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign timeout_err = tmo_q;
    assign pass_cnt    = pass_q;
    assign fail_cnt    = fail_q;

    // FIFO pointers and occupancy; a push and pop in the same cycle cancel out
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // vector storage; entries are only read while occupied, so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {vec_key, vec_pt, vec_exp};
    end

    // run sequencing: load the head vector, wait for the core, score and pop
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            core_ld_q   <= 1'b0;
            tmo_q       <= 1'b0;
            timed_out_q <= 1'b0;
            done_prev_q <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            ct_q        <= '0;
        end else begin
            done_prev_q <= core_done;
            core_ld_q   <= 1'b0;
            case (state_q)
                IDLE, DONE: if (run_start) begin
                    state_q    <= LOAD;
                    core_ld_q  <= 1'b1;
                    busy_q     <= 1'b1;
                    finished_q <= 1'b0;
                    pass_q     <= '0;
                    fail_q     <= '0;
                    tmo_q      <= 1'b0;
                    idx_q      <= '0;
                end
                LOAD: begin
                    state_q <= WAIT;
                    wcnt_q  <= '0;
                end
                WAIT: if (done_rise) begin
                    state_q     <= CHECK;
                    ct_q        <= core_ct;
                    timed_out_q <= 1'b0;
                end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
                    state_q     <= CHECK;
                    ct_q        <= '0;
                    timed_out_q <= 1'b1;
                    tmo_q       <= 1'b1;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
                CHECK: begin
                    if (fail_now) fail_q <= sat_inc(fail_q);
                    else pass_q <= sat_inc(pass_q);
                    idx_q <= sat_inc(idx_q);
                    if (cnt_d != '0) begin
                        state_q   <= LOAD;
                        core_ld_q <= 1'b1;
                    end else begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        finished_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AES_SEQ_MISMATCH_LOG_EN
    logic               ff_seen_q;
    logic [CNT_W-1:0]   ff_idx_q;
    logic [127:0]       ff_ct_q;

    // latch the first failing vector of each run; cleared when a run starts
    always_ff @(posedge clk) begin
        if (!reset || run_start) begin
            ff_seen_q <= 1'b0;
            ff_idx_q  <= '0;
            ff_ct_q   <= '0;
        end else if (state_q == CHECK && fail_now && !ff_seen_q) begin
            ff_seen_q <= 1'b1;
            ff_idx_q  <= idx_q;
            ff_ct_q   <= ct_q;
        end
    end

    assign first_fail_idx = ff_idx_q;
    assign first_fail_ct  = ff_ct_q;
`else
    assign first_fail_idx = '0;
    assign first_fail_ct  = '0;
`endif

endmodule
